// File: rtl/proc_pkg.sv
// Shared types and default widths for the processor/DMA memory arbiter.
package proc_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    // Bus ownership states; CPU_OWN is the reset state.
    typedef enum logic [1:0] {
        CPU_OWN   = 2'd0,
        DMA_OWN   = 2'd1,
        CPU_GUARD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/proc_mem_arbiter_fsm.sv
// Ownership FSM: state register, DMA burst counter and next-state logic.
// dma_gnt/cpu_rdy are decoded from the registered state only, so an
// asynchronous reset drops the grant without waiting for a clock.
module arb_fsm
    import proc_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dma_req_i,
    output arb_state_t state_o,
    output logic       dma_gnt_o,
    output logic       cpu_rdy_o
);

    // Burst counter of 8 bits covers the full legal MAX_BURST range (1..255).
    localparam logic [7:0] LAST_ACCESS = 8'(MAX_BURST - 1);

    arb_state_t state_q, state_d;
    logic [7:0] burst_q, burst_d;

    // State and burst counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CPU_OWN;
            burst_q <= 8'd0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic; a DMA_OWN cycle with dma_req low ends the burst
    // before the burst-length limit is considered.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            CPU_OWN: begin
                if (dma_req_i) begin
                    state_d = DMA_OWN;
                    burst_d = 8'd0;
                end
            end
            DMA_OWN: begin
                if (!dma_req_i) begin
                    state_d = CPU_GUARD;
                end else begin
                    burst_d = burst_q + 8'd1;
                    if (burst_q == LAST_ACCESS) begin
                        state_d = CPU_GUARD;
                    end
                end
            end
            CPU_GUARD: begin
                // One guaranteed CPU cycle; dma_req is deliberately ignored.
                state_d = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    assign state_o   = state_q;
    assign dma_gnt_o = (state_q == DMA_OWN);
    assign cpu_rdy_o = (state_q != DMA_OWN);

endmodule

// File: rtl/proc_mem_arbiter.sv
// Shares one memory array between the 6502 core and a DMA/program-loader
// port. The CPU owns the bus by default; DMA takes it by request/grant and
// stalls the core through cpu_rdy. Memory read data is asynchronous.
module proc_mem_arbiter
    import proc_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    input  logic                  cpu_wr_enable,
    output logic [DATA_WIDTH-1:0] cpu_rd_data,
    output logic                  cpu_rdy,
    input  logic                  dma_req,
    output logic                  dma_gnt,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_wr_enable,
    output logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_enable,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [15:0]           stall_count
);

    arb_state_t state;
    logic [15:0] stall_count_q, stall_count_d;

    arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk_i     (clk),
        .rst_i     (reset),
        .dma_req_i (dma_req),
        .state_o   (state),
        .dma_gnt_o (dma_gnt),
        .cpu_rdy_o (cpu_rdy)
    );

    // Bus mux: DMA drives memory only while it owns the bus, and a DMA
    // write is qualified by dma_req so the release cycle never writes.
    always_comb begin
        mem_address   = cpu_address;
        mem_wr_data   = cpu_wr_data;
        mem_wr_enable = cpu_wr_enable;
        if (state == DMA_OWN) begin
            mem_address   = dma_address;
            mem_wr_data   = dma_wr_data;
            mem_wr_enable = dma_wr_enable & dma_req;
        end
    end

    assign cpu_rd_data = mem_rd_data;
    assign dma_rd_data = mem_rd_data;

    // Saturating count of core stall cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (!cpu_rdy && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Stall counter register; cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= 16'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
